mem_wr_arbiter: RTL and testbench

//   Shares the single registered write port of DMEM/IMEM between two requesters: the
//   CPU store path (MEM stage) and the program loader (UART/debug bulk-write master).
//   CPU stores have priority. A starvation guard stalls the CPU for one cycle to drain
//   the loader. Forms byte-lane write enables and lane-replicated write data, and decodes
//   the target region from address bits 28 (DMEM) and 29 (IMEM).

---
 rtl/mem_wr_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_mem_wr_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wr_arbiter.sv
// ---------------------------------------------------------------------------
// mem_wr_arbiter
//   Shares the single registered write port of DMEM/IMEM between the CPU store
//   path (MEM stage) and the program loader (bulk-write master). CPU stores win
//   by default. A starvation guard stalls the CPU for one cycle so a waiting
//   loader write can drain. In bootloader mode (i_ldr_lock) the loader owns the
//   port outright. Produces byte-lane write enables, lane-replicated write data
//   and the target region from address bits 28 (DMEM) and 29 (IMEM).
//
// Ports
//   i_clk, i_rst        core clock, synchronous active-high reset
//   i_cpu_st_valid      MEM-stage store present
//   i_cpu_addr/_wdata   store byte address / data (value in low bits)
//   i_cpu_funct3        000=SB 001=SH 010=SW, others write nothing
//   i_cpu_pc30          PC[30] of the store; IMEM writes need it set
//   o_cpu_stall         combinational: CPU must hold its MEM stage
//   i_ldr_valid         loader write request
//   o_ldr_ready         combinational: loader request accepted this cycle
//   i_ldr_addr/_wdata   loader word address (bits 1:0 ignored) / data
//   i_ldr_wstrb         loader byte strobes
//   i_ldr_lock          bootloader mode: loader owns the port
//   o_mem_addr          registered word address (addr[ADDR_W+1:2])
//   o_mem_wdata         registered lane-replicated write data
//   o_dmem_we/o_imem_we registered byte enables per memory
//   o_misalign          registered one-cycle pulse for a dropped SH/SW
// ---------------------------------------------------------------------------
module mem_wr_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_st_valid,
  input  logic [31:0]       i_cpu_addr,
  input  logic [31:0]       i_cpu_wdata,
  input  logic [2:0]        i_cpu_funct3,
  input  logic              i_cpu_pc30,
  output logic              o_cpu_stall,
  input  logic              i_ldr_valid,
  output logic              o_ldr_ready,
  input  logic [31:0]       i_ldr_addr,
  input  logic [31:0]       i_ldr_wdata,
  input  logic [3:0]        i_ldr_wstrb,
  input  logic              i_ldr_lock,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_dmem_we,
  output logic [3:0]        o_imem_we,
  output logic              o_misalign
);

  localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_SHARE = 2'd0,
    ST_FORCE = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic              w_cpu_grant;
  logic              w_ldr_grant;
  logic [3:0]        w_we;
  logic [31:0]       w_data;
  logic [31:0]       w_addr;
  logic              w_imem_ok;
  logic              w_mis;
  logic [3:0]        w_dmem_we;
  logic [3:0]        w_imem_we;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_starve_hit;
  logic              w_unused;

  // Byte enables for a CPU store; misaligned or non-store funct3 writes nothing.
  function automatic logic [3:0] cpu_lane_we(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] we;
    we = 4'b0000;
    case (f3)
      3'b000:  we = 4'b0001 << a;
      3'b001:  we = a[0] ? 4'b0000 : (a[1] ? 4'b1100 : 4'b0011);
      3'b010:  we = (a == 2'b00) ? 4'b1111 : 4'b0000;
      default: we = 4'b0000;
    endcase
    return we;
  endfunction

  // Replicate the store value across all lanes it could land in.
  function automatic logic [31:0] cpu_lane_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    case (f3)
      3'b000:  r = {4{d[7:0]}};
      3'b001:  r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // SH needs halfword alignment, SW needs word alignment.
  function automatic logic cpu_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic m;
    m = 1'b0;
    case (f3)
      3'b001:  m = a[0];
      3'b010:  m = (a != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Address bits outside the word index and region bits are intentionally ignored.
  assign w_unused = ^{i_cpu_addr, i_ldr_addr};

  // Grant selection, lane formation, region decode and starve-count next value.
  always_comb begin
    w_cpu_grant  = 1'b0;
    w_ldr_grant  = 1'b0;
    o_cpu_stall  = 1'b0;
    w_we         = 4'b0000;
    w_data       = 32'h0000_0000;
    w_addr       = 32'h0000_0000;
    w_imem_ok    = 1'b0;
    w_mis        = 1'b0;
    w_cnt_next   = r_cnt;
    w_starve_hit = 1'b0;

    // FORCE and LOCK hand the port to the loader; the CPU waits.
    if (r_state != ST_SHARE) begin
      o_cpu_stall = i_cpu_st_valid;
      w_ldr_grant = i_ldr_valid;
      w_cpu_grant = 1'b0;
    end else begin
      o_cpu_stall = 1'b0;
      w_cpu_grant = i_cpu_st_valid;
      w_ldr_grant = i_ldr_valid & ~i_cpu_st_valid;
    end

    if (w_ldr_grant) begin
      w_we      = i_ldr_wstrb;
      w_data    = i_ldr_wdata;
      w_addr    = i_ldr_addr;
      w_imem_ok = 1'b1;
      w_mis     = 1'b0;
    end else if (w_cpu_grant) begin
      w_we      = cpu_lane_we(i_cpu_funct3, i_cpu_addr[1:0]);
      w_data    = cpu_lane_data(i_cpu_funct3, i_cpu_wdata);
      w_addr    = i_cpu_addr;
      w_imem_ok = i_cpu_pc30;
      w_mis     = cpu_misaligned(i_cpu_funct3, i_cpu_addr[1:0]);
    end else begin
      w_we      = 4'b0000;
      w_imem_ok = 1'b0;
      w_mis     = 1'b0;
    end

    // Count consecutive cycles the loader was blocked by a CPU grant.
    if (w_ldr_grant || !i_ldr_valid) begin
      w_cnt_next = {CNT_W{1'b0}};
    end else if (w_cpu_grant) begin
      w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_W'(1));
    end else begin
      w_cnt_next = r_cnt;
    end

    // The cycle in which the blocked count reaches its limit is the last one
    // the CPU wins; the following cycle is FORCE.
    w_starve_hit = i_ldr_valid & w_cpu_grant & (w_cnt_next == CNT_MAX);
  end

  assign o_ldr_ready = w_ldr_grant;
  assign w_dmem_we   = w_addr[28] ? w_we : 4'b0000;
  assign w_imem_we   = (w_addr[29] & w_imem_ok) ? w_we : 4'b0000;

  // FSM, starve counter and registered write-port outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_SHARE;
      r_cnt       <= {CNT_W{1'b0}};
      o_mem_addr  <= {ADDR_W{1'b0}};
      o_mem_wdata <= 32'h0000_0000;
      o_dmem_we   <= 4'b0000;
      o_imem_we   <= 4'b0000;
      o_misalign  <= 1'b0;
    end else begin
      if (i_ldr_lock) begin
        r_state <= ST_LOCK;
      end else begin
        case (r_state)
          ST_SHARE: r_state <= w_starve_hit ? ST_FORCE : ST_SHARE;
          ST_FORCE: r_state <= ST_SHARE;
          ST_LOCK:  r_state <= ST_SHARE;
          default:  r_state <= ST_SHARE;
        endcase
      end
      r_cnt <= w_cnt_next;

      // Address and data follow any grant; they hold across idle cycles.
      if (w_cpu_grant || w_ldr_grant) begin
        o_mem_addr  <= w_addr[ADDR_W+1:2];
        o_mem_wdata <= w_data;
      end else begin
        o_mem_addr  <= o_mem_addr;
        o_mem_wdata <= o_mem_wdata;
      end
      o_dmem_we  <= w_dmem_we;
      o_imem_we  <= w_imem_we;
      o_misalign <= w_mis;
    end
  end

endmodule

// File: tb/tb_mem_wr_arbiter.sv
module tb_mem_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_st_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic        cpu_pc30;
  logic        cpu_stall;
  logic        ldr_valid;
  logic        ldr_ready;
  logic [31:0] ldr_addr;
  logic [31:0] ldr_wdata;
  logic [3:0]  ldr_wstrb;
  logic        ldr_lock;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  dmem_we;
  logic [3:0]  imem_we;
  logic        misalign;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_wr_arbiter #(.ADDR_W(14), .STARVE_LIMIT(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_st_valid(cpu_st_valid), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .i_cpu_funct3(cpu_funct3), .i_cpu_pc30(cpu_pc30), .o_cpu_stall(cpu_stall),
    .i_ldr_valid(ldr_valid), .o_ldr_ready(ldr_ready), .i_ldr_addr(ldr_addr),
    .i_ldr_wdata(ldr_wdata), .i_ldr_wstrb(ldr_wstrb), .i_ldr_lock(ldr_lock),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_dmem_we(dmem_we),
    .o_imem_we(imem_we), .o_misalign(misalign)
  );

  typedef struct {
    logic        cv;
    logic [31:0] ca;
    logic [31:0] cd;
    logic [2:0]  f3;
    logic        pc;
    logic        lv;
    logic [31:0] la;
    logic [31:0] ld;
    logic [3:0]  ls;
    logic        e_stall;
    logic        e_ready;
    logic [3:0]  e_dwe;
    logic [3:0]  e_iwe;
    logic        e_mis;
    logic        chkd;
    logic [13:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic cv, input logic [31:0] ca, input logic [31:0] cd,
                     input logic [2:0] f3, input logic pc, input logic lv,
                     input logic [31:0] la, input logic [31:0] ld, input logic [3:0] ls,
                     input logic es, input logic er, input logic [3:0] ed,
                     input logic [3:0] ei, input logic em, input logic ck,
                     input logic [13:0] ea, input logic [31:0] edat);
    vec_t v;
    v.cv = cv; v.ca = ca; v.cd = cd; v.f3 = f3; v.pc = pc;
    v.lv = lv; v.la = la; v.ld = ld; v.ls = ls;
    v.e_stall = es; v.e_ready = er; v.e_dwe = ed; v.e_iwe = ei; v.e_mis = em;
    v.chkd = ck; v.e_addr = ea; v.e_data = edat;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    cpu_st_valid = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_funct3 = 3'b000;
    cpu_pc30 = 1'b0; ldr_valid = 1'b0; ldr_addr = 32'h0; ldr_wdata = 32'h0;
    ldr_wstrb = 4'b0000; ldr_lock = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic starve_inputs();
    cpu_st_valid = 1'b1; cpu_addr = 32'h1000_0000; cpu_wdata = 32'h0000_0001;
    cpu_funct3 = 3'b010; cpu_pc30 = 1'b0;
    ldr_valid = 1'b1; ldr_addr = 32'h1000_0040; ldr_wdata = 32'h0000_0002;
    ldr_wstrb = 4'b1111;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    //            cv ca            cd            f3     pc lv la            ld            ls       st rd dwe      iwe      mis chk addr      data
    add(1'b1, 32'h1000_0003, 32'h0000_00AB, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b1, 14'd0, 32'hABAB_ABAB);
    add(1'b1, 32'h1000_0001, 32'h0000_1234, 3'b001, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 14'd0, 32'h0);
    add(1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 14'd0, 32'h0);
    add(1'b1, 32'h2000_0008, 32'hCAFE_F00D, 3'b010, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b1, 14'd2, 32'hCAFE_F00D);
    add(1'b1, 32'h1000_0006, 32'h5555_BEEF, 3'b001, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b1100, 4'b0000, 1'b0, 1'b1, 14'd1, 32'hBEEF_BEEF);
    add(1'b1, 32'h1000_0000, 32'h0000_7777, 3'b001, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0011, 4'b0000, 1'b0, 1'b1, 14'd0, 32'h7777_7777);
    add(1'b1, 32'h3000_0001, 32'h0000_0012, 3'b000, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 1'b1, 14'd0, 32'h1212_1212);
    add(1'b1, 32'h3000_0001, 32'h0000_0034, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 14'd0, 32'h3434_3434);
    add(1'b1, 32'h1000_0002, 32'h1111_2222, 3'b010, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 14'd0, 32'h0);
    add(1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 3'b100, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 14'd0, 32'h0);
    add(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, 32'h3000_0010, 32'h1122_3344, 4'b1111, 1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1, 14'd4, 32'h1122_3344);
    add(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, 32'h2000_0022, 32'hA5A5_5A5A, 4'b0101, 1'b0, 1'b1, 4'b0000, 4'b0101, 1'b0, 1'b1, 14'd8, 32'hA5A5_5A5A);
    add(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 14'd8, 32'hA5A5_5A5A);
    add(1'b1, 32'h1000_0004, 32'h0000_0077, 3'b000, 1'b0, 1'b1, 32'h1000_0000, 32'h0000_0099, 4'b1111, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 14'd1, 32'h7777_7777);
    add(1'b1, 32'h1001_FFFC, 32'h89AB_CDEF, 3'b010, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 14'h3FFF, 32'h89AB_CDEF);
    add(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, 32'h0000_0040, 32'h5555_5555, 4'b1111, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 14'd0, 32'h0);

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_dmem_we", 32'(dmem_we), 32'h0);
    chk("rst_imem_we", 32'(imem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'h0);
    chk("rst_ldr_ready", 32'(ldr_ready), 32'h0);

    // Table-driven single-cycle vectors
    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      cpu_st_valid = vecs[i].cv; cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cd;
      cpu_funct3 = vecs[i].f3; cpu_pc30 = vecs[i].pc;
      ldr_valid = vecs[i].lv; ldr_addr = vecs[i].la; ldr_wdata = vecs[i].ld;
      ldr_wstrb = vecs[i].ls; ldr_lock = 1'b0;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_ready", i), 32'(ldr_ready), 32'(vecs[i].e_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_dmem_we", i), 32'(dmem_we), 32'(vecs[i].e_dwe));
      chk($sformatf("v%0d_imem_we", i), 32'(imem_we), 32'(vecs[i].e_iwe));
      chk($sformatf("v%0d_misalign", i), 32'(misalign), 32'(vecs[i].e_mis));
      if (vecs[i].chkd) begin
        chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_data);
      end
    end

    // Starvation guard: 7 CPU wins, one forced loader cycle, then CPU again
    do_reset();
    starve_inputs();
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("starve_c%0d_stall", c), 32'(cpu_stall), 32'(c == 7));
      chk($sformatf("starve_c%0d_ready", c), 32'(ldr_ready), 32'(c == 7));
      @(posedge clk);
      #1;
      chk($sformatf("starve_c%0d_addr", c), 32'(mem_addr), (c == 7) ? 32'd16 : 32'd0);
      chk($sformatf("starve_c%0d_data", c), mem_wdata, (c == 7) ? 32'd2 : 32'd1);
      @(negedge clk);
    end

    // Reset while in FORCE with a pending loader request
    do_reset();
    starve_inputs();
    for (int c = 0; c < 7; c++) begin
      #1;
      chk($sformatf("rf_c%0d_stall", c), 32'(cpu_stall), 32'h0);
      @(negedge clk);
    end
    #1;
    chk("rf_force_stall", 32'(cpu_stall), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rf_dmem_we", 32'(dmem_we), 32'h0);
    chk("rf_imem_we", 32'(imem_we), 32'h0);
    chk("rf_mem_addr", 32'(mem_addr), 32'h0);
    chk("rf_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("rf_post_c%0d_stall", c), 32'(cpu_stall), 32'(c == 7));
      chk($sformatf("rf_post_c%0d_ready", c), 32'(ldr_ready), 32'(c == 7));
      @(negedge clk);
    end

    // Bootloader lock: 16-word IMEM burst while the CPU is held
    do_reset();
    ldr_lock = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      ldr_valid = 1'b1; ldr_addr = 32'h2000_0000 + 32'(4 * i);
      ldr_wdata = 32'(i); ldr_wstrb = 4'b1111;
      cpu_st_valid = i[0]; cpu_addr = 32'h1000_0000; cpu_wdata = 32'hFFFF_FFFF;
      cpu_funct3 = 3'b010; cpu_pc30 = 1'b1;
      #1;
      chk($sformatf("lock_%0d_stall", i), 32'(cpu_stall), 32'(i[0]));
      chk($sformatf("lock_%0d_ready", i), 32'(ldr_ready), 32'h1);
      @(posedge clk);
      #1;
      chk($sformatf("lock_%0d_imem_we", i), 32'(imem_we), 32'hF);
      chk($sformatf("lock_%0d_dmem_we", i), 32'(dmem_we), 32'h0);
      chk($sformatf("lock_%0d_addr", i), 32'(mem_addr), 32'(i));
      chk($sformatf("lock_%0d_data", i), mem_wdata, 32'(i));
      @(negedge clk);
    end
    ldr_lock = 1'b0; ldr_valid = 1'b0;
    cpu_st_valid = 1'b1; cpu_addr = 32'h1000_0000; cpu_wdata = 32'h5A5A_5A5A;
    cpu_funct3 = 3'b010;
    #1;
    chk("unlock_stall_last", 32'(cpu_stall), 32'h1);
    @(posedge clk);
    #1;
    chk("unlock_dmem_held", 32'(dmem_we), 32'h0);
    @(negedge clk);
    #1;
    chk("unlock_stall_clear", 32'(cpu_stall), 32'h0);
    @(posedge clk);
    #1;
    chk("unlock_dmem_we", 32'(dmem_we), 32'hF);
    chk("unlock_data", mem_wdata, 32'h5A5A_5A5A);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
